// File: rtl/fir_decim_out.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : fir_decim_out
// Description : Integrate-and-dump decimator placed after fir_filter. It
//               averages DECIM consecutive samples (boxcar), buffers each
//               result in a small circular FIFO and delivers it over a
//               valid/ready handshake. When a result is dropped, a sticky
//               overflow flag is set.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decim_out #(
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [17:0]        in_sig,
  input  logic                      in_strobe,
  output logic signed [17:0]        out_sig,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow
);

  localparam int c_SHIFT = $clog2(DECIM);
  localparam int c_AW    = 18 + c_SHIFT;
  localparam int c_PW    = $clog2(DEPTH);
  localparam int c_LW    = c_PW + 1;

  localparam logic [c_SHIFT-1:0] c_PH_LAST = c_SHIFT'(DECIM - 1);
  localparam logic [c_LW-1:0]    c_FULL    = c_LW'(DEPTH);

  // Accumulation state
  logic [c_SHIFT-1:0]      r_ph;
  logic signed [c_AW-1:0]  r_acc;

  // FIFO state
  logic [17:0]             r_mem [DEPTH];
  logic [c_PW-1:0]         r_wr;
  logic [c_PW-1:0]         r_rd;
  logic [c_LW-1:0]         r_level;
  logic                    r_overflow;

  // Datapath / control wires
  logic signed [c_AW-1:0]  w_in_ext;
  logic signed [c_AW-1:0]  w_sum;
  logic [17:0]             w_result;
  logic                    w_dump;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;

  // Running sum including the current sample. The upper 18 bits of the sum
  // are exactly the arithmetic right shift by log2(DECIM), kept to 18 bits:
  // the floor-rounded average.
  always_comb begin
    w_in_ext = {{c_SHIFT{in_sig[17]}}, in_sig};
    w_sum    = r_acc + w_in_ext;
    w_result = w_sum[c_AW-1:c_SHIFT];
  end

  // Push/pop decisions; a pop in the dump cycle frees a slot for the push.
  always_comb begin
    w_dump = in_strobe && (r_ph == c_PH_LAST);
    w_full = (r_level == c_FULL);
    w_pop  = out_valid && out_ready;
    w_push = w_dump && (!w_full || w_pop);
    w_drop = w_dump && w_full && !w_pop;
  end

  // Phase counter and accumulator; a group restarts on every ph==0 strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph  <= '0;
      r_acc <= '0;
    end else if (in_strobe) begin
      r_ph <= r_ph + 1'b1;
      if (r_ph == '0) begin
        r_acc <= w_in_ext;
      end else begin
        r_acc <= w_sum;
      end
    end
  end

  // FIFO storage; contents need no reset because the level gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= w_result;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Output head; forced to zero while empty so the reset value is defined.
  always_comb begin
    out_valid  = (r_level != '0);
    out_sig    = out_valid ? r_mem[r_rd] : '0;
    fifo_level = r_level;
    overflow   = r_overflow;
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_out.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_fir_decim_out
// Description : Scoreboard bench for fir_decim_out (DECIM=4, DEPTH=4).
//               Stimulus pushes hand-computed results into a queue; a
//               monitor pops and compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_decim_out;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [17:0] in_sig;
  logic               in_strobe;
  logic signed [17:0] out_sig;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         fifo_level;
  logic               overflow;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  fir_decim_out #(
    .DECIM(4),
    .DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_sig     (in_sig),
    .in_strobe  (in_strobe),
    .out_sig    (out_sig),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare every transfer against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0d expected none", out_sig);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("out_sig", int'(out_sig), e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    in_sig    = 18'(v);
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic send_group(input int v);
    repeat (4) send(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
    tick();
    check({name, "_valid_low"}, int'(out_valid), 0);
    check({name, "_level_zero"}, int'(fifo_level), 0);
  endtask

  // Hard stop if something never completes.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int bb_exp [4] = '{1, 5, 9, 13};

    rst       = 1'b1;
    in_sig    = '0;
    in_strobe = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("reset_level", int'(fifo_level), 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_out_sig", int'(out_sig), 0);
    check("reset_overflow", int'(overflow), 0);
    rst = 1'b0;

    // Ramp: average 250, valid for exactly one cycle after the 4th strobe
    send(100);
    send(200);
    send(300);
    check("ramp_valid_before", int'(out_valid), 0);
    exp_q.push_back(250);
    send(400);
    check("ramp_valid_rise", int'(out_valid), 1);
    tick();
    check("ramp_valid_fall", int'(out_valid), 0);
    drain("ramp_drain");

    // Negative and positive floor rounding
    exp_q.push_back(-2);
    send(-1); send(-1); send(-1); send(-2);
    exp_q.push_back(1);
    send(1); send(1); send(1); send(2);
    drain("round_drain");

    // Full-scale extremes without wrap
    exp_q.push_back(131071);
    send_group(131071);
    exp_q.push_back(-131072);
    send_group(-131072);
    drain("fullscale_drain");

    // Backpressure and overflow: 5th result dropped
    do_reset();
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(v);
      send_group(v);
      if (v == 4) begin
        check("ovf_level_at4", int'(fifo_level), 4);
        check("ovf_flag_at4", int'(overflow), 0);
      end
    end
    check("ovf_level_at5", int'(fifo_level), 4);
    check("ovf_flag_at5", int'(overflow), 1);
    out_ready = 1'b1;
    drain("ovf_drain");
    check("ovf_sticky", int'(overflow), 1);

    // Full FIFO with pop and push in the same cycle
    do_reset();
    check("reset_clears_overflow", int'(overflow), 0);
    out_ready = 1'b0;
    exp_q.push_back(10); send_group(10);
    exp_q.push_back(20); send_group(20);
    exp_q.push_back(30); send_group(30);
    exp_q.push_back(40); send_group(40);
    check("simul_level_full", int'(fifo_level), 4);
    exp_q.push_back(50);
    send(50); send(50); send(50);
    out_ready = 1'b1;
    send(50);
    out_ready = 1'b0;
    check("simul_level_kept", int'(fifo_level), 4);
    check("simul_no_overflow", int'(overflow), 0);
    out_ready = 1'b1;
    drain("simul_drain");

    // Reset mid-group, with a strobe coincident with reset
    do_reset();
    send(1000);
    send(1000);
    rst       = 1'b1;
    in_sig    = 18'(1000);
    in_strobe = 1'b1;
    tick();
    rst       = 1'b0;
    in_strobe = 1'b0;
    exp_q.delete();
    check("midrst_level", int'(fifo_level), 0);
    exp_q.push_back(8);
    send_group(8);
    drain("midrst_drain");

    // Back-to-back strobes 0..15
    for (int i = 0; i < 16; i++) begin
      if ((i % 4) == 3) exp_q.push_back(bb_exp[i / 4]);
      send(i);
    end
    drain("b2b_drain");

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
